// File: rtl/apb_timer.sv
// apb_timer: 32-bit down-counting APB timer with prescaler, auto-reload or
// one-shot operation and a level interrupt. Zero wait-state slave on PCLK.
module apb_timer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int PRE_W      = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    TIMER_IRQ
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [4:0] ADDR_CTRL      = 5'h00;
  localparam logic [4:0] ADDR_VALUE     = 5'h04;
  localparam logic [4:0] ADDR_RELOAD    = 5'h08;
  localparam logic [4:0] ADDR_PRESCALE  = 5'h0C;
  localparam logic [4:0] ADDR_INTSTATUS = 5'h10;

  logic                  ctrl_en;
  logic                  ctrl_irq_en;
  logic                  ctrl_oneshot;
  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] reload_q;
  logic [PRE_W-1:0]      prescale_q;
  logic [PRE_W-1:0]      pcnt;
  logic                  pending;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] wmask;

  logic [4:0] addr;
  logic       addr_err;
  logic       access_phase;
  logic       wr_en;
  logic       rd_setup;
  logic       wr_ctrl;
  logic       wr_value;
  logic       wr_reload;
  logic       wr_prescale;
  logic       wr_status;
  logic       tick;
  logic       value_zero;
  logic       expire;

  // Protection bits and the undecoded upper address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{PPROT, PADDR[ADDR_WIDTH-1:5]};

  assign addr         = PADDR[4:0];
  assign addr_err     = (addr > ADDR_INTSTATUS) || (addr[1:0] != 2'b00);
  assign access_phase = PSEL & PENABLE;
  assign wr_en        = access_phase & PWRITE & ~addr_err;
  assign rd_setup     = PSEL & ~PENABLE & ~PWRITE;

  assign wr_ctrl     = wr_en && (addr == ADDR_CTRL) && PSTRB[0];
  assign wr_value    = wr_en && (addr == ADDR_VALUE);
  assign wr_reload   = wr_en && (addr == ADDR_RELOAD);
  assign wr_prescale = wr_en && (addr == ADDR_PRESCALE);
  assign wr_status   = wr_en && (addr == ADDR_INTSTATUS) && PSTRB[0] && PWDATA[0];

  assign tick       = ctrl_en && (pcnt == prescale_q);
  assign value_zero = (value_q == '0);
  assign expire     = tick && value_zero;

  assign PREADY    = 1'b1;
  assign PSLVERR   = access_phase & addr_err;
  assign PRDATA    = PSLVERR ? '0 : prdata_q;
  assign TIMER_IRQ = pending & ctrl_irq_en;

  // Expand the byte strobes into a per-bit write mask.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      wmask[i*8 +: 8] = {8{PSTRB[i]}};
    end
  end

  // Read-data selection for the addressed register; unmapped locations read 0.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CTRL:      rd_mux = {{(DATA_WIDTH-3){1'b0}}, ctrl_oneshot, ctrl_irq_en, ctrl_en};
      ADDR_VALUE:     rd_mux = value_q;
      ADDR_RELOAD:    rd_mux = reload_q;
      ADDR_PRESCALE:  rd_mux = {{(DATA_WIDTH-PRE_W){1'b0}}, prescale_q};
      ADDR_INTSTATUS: rd_mux = {{(DATA_WIDTH-1){1'b0}}, pending};
      default:        rd_mux = '0;
    endcase
  end

  // Control bits; a one-shot expiry drops EN, but a CTRL write on that edge wins.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ctrl_en      <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      ctrl_oneshot <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en      <= PWDATA[0];
      ctrl_irq_en  <= PWDATA[1];
      ctrl_oneshot <= PWDATA[2];
    end else if (expire && ctrl_oneshot) begin
      ctrl_en <= 1'b0;
    end
  end

  // Counter value: bus writes take priority over the tick decrement or reload.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      value_q <= '0;
    end else if (wr_value) begin
      value_q <= (value_q & ~wmask) | (PWDATA & wmask);
    end else if (tick) begin
      value_q <= value_zero ? reload_q : value_q - DATA_WIDTH'(1);
    end
  end

  // Reload and prescale registers, byte-lane masked.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      reload_q   <= '0;
      prescale_q <= '0;
    end else begin
      if (wr_reload) begin
        reload_q <= (reload_q & ~wmask) | (PWDATA & wmask);
      end
      if (wr_prescale) begin
        prescale_q <= (prescale_q & ~wmask[PRE_W-1:0]) | (PWDATA[PRE_W-1:0] & wmask[PRE_W-1:0]);
      end
    end
  end

  // Prescaler counter restarts on ticks and on any VALUE or PRESCALE write.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pcnt <= '0;
    end else if (!ctrl_en || wr_value || wr_prescale || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRE_W'(1);
    end
  end

  // Pending flag: an expiry on the same edge as a write-1-to-clear keeps it set.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pending <= 1'b0;
    end else if (expire) begin
      pending <= 1'b1;
    end else if (wr_status) begin
      pending <= 1'b0;
    end
  end

  // Read data is captured in the setup phase and held through the access phase.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      prdata_q <= '0;
    end else if (rd_setup) begin
      prdata_q <= rd_mux;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: table-driven register checks, hand-written timing corner
// cases and randomized periods compared with closed-form period arithmetic.
module tb_apb_timer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [15:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [2:0]  PPROT = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        TIMER_IRQ;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expData;
    logic        expErr;
  } apbVecT;

  apbVecT vecs[20];

  apb_timer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .PRE_W(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TIMER_IRQ(TIMER_IRQ)
  );

  // Free-running clock and an edge counter used to time interrupts.
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One complete APB transfer; called and returns 1 time unit after an edge.
  task automatic applyStimulus(input logic wr, input logic [15:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] rd,
                               output logic er, output logic rdy);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    rd = PRDATA; er = PSLVERR; rdy = PREADY;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbWrite(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd; logic er; logic rdy;
    applyStimulus(1'b1, a, d, 4'hF, rd, er, rdy);
  endtask

  task automatic apbRead(input logic [15:0] a, output logic [31:0] d);
    logic er; logic rdy;
    applyStimulus(1'b0, a, 32'h0, 4'h0, d, er, rdy);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  // Wait for the interrupt with a bound; delta is edges elapsed since startCyc.
  task automatic waitIrq(input int startCyc, output int delta);
    while (!TIMER_IRQ && (cyc - startCyc) < 300) begin
      @(posedge PCLK); #1;
    end
    delta = cyc - startCyc;
  endtask

  // Stop the timer and clear any pending interrupt.
  task automatic stopTimer();
    apbWrite(16'h00, 32'h0);
    apbWrite(16'h10, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    int          t0;
    int          t1;
    int          delta;
    int          p, r, v;
    logic        os;

    vecs[0]  = '{1'b0, 16'h00, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 16'h04, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 16'h08, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 16'h0C, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 16'h10, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 16'h08, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 16'h08, 32'h12345678, 4'h5, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 16'h08, 32'h0,        4'h0, 32'hFF34FF78, 1'b0};
    vecs[8]  = '{1'b1, 16'h0C, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 16'h0C, 32'h0,        4'h0, 32'h000000FF, 1'b0};
    vecs[10] = '{1'b1, 16'h04, 32'hAABBCCDD, 4'hC, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 16'h04, 32'h0,        4'h0, 32'hAABB0000, 1'b0};
    vecs[12] = '{1'b1, 16'h00, 32'h00000007, 4'hE, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 16'h00, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 16'h14, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[15] = '{1'b1, 16'h06, 32'h55555555, 4'hF, 32'h0,        1'b1};
    vecs[16] = '{1'b0, 16'h04, 32'h0,        4'h0, 32'hAABB0000, 1'b0};
    vecs[17] = '{1'b0, 16'h08, 32'h0,        4'h0, 32'hFF34FF78, 1'b0};
    vecs[18] = '{1'b0, 16'h1C, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[19] = '{1'b0, 16'h0C, 32'h0,        4'h0, 32'h000000FF, 1'b0};

    PRESETn = 1'b0;
    repeat (5) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    checkOutput("reset_irq", {31'h0, TIMER_IRQ}, 32'h0);
    checkOutput("reset_slverr", {31'h0, PSLVERR}, 32'h0);
    checkOutput("reset_ready", {31'h0, PREADY}, 32'h1);

    $display("[TB] register table");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, er, rdy);
      checkOutput($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d_ready", i), {31'h0, rdy}, 32'h1);
      if (!vecs[i].write || vecs[i].expErr) begin
        checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].expData);
      end
    end

    $display("[TB] periodic");
    apbWrite(16'h08, 32'd3);
    apbWrite(16'h04, 32'd3);
    apbWrite(16'h0C, 32'd1);
    apbWrite(16'h00, 32'h3);
    t0 = cyc;
    waitIrq(t0, delta);
    checkOutput("periodic_first", delta, 32'd8);
    t1 = cyc;
    apbRead(16'h04, rd);
    checkOutput("periodic_value_reload", rd, 32'd3);
    apbWrite(16'h10, 32'h1);
    checkOutput("periodic_w1c", {31'h0, TIMER_IRQ}, 32'h0);
    waitIrq(t1, delta);
    checkOutput("periodic_second", delta, 32'd8);
    stopTimer();

    $display("[TB] one-shot");
    apbWrite(16'h08, 32'd5);
    apbWrite(16'h04, 32'd2);
    apbWrite(16'h0C, 32'd0);
    apbWrite(16'h00, 32'h7);
    t0 = cyc;
    waitIrq(t0, delta);
    checkOutput("oneshot_delay", delta, 32'd3);
    apbRead(16'h00, rd);
    checkOutput("oneshot_ctrl", rd, 32'h6);
    apbRead(16'h04, rd);
    checkOutput("oneshot_value", rd, 32'd5);
    stopTimer();

    $display("[TB] collisions");
    apbWrite(16'h08, 32'd3);
    apbWrite(16'h04, 32'd3);
    apbWrite(16'h00, 32'h3);
    idleCycles(2);
    apbWrite(16'h10, 32'h1);
    apbRead(16'h10, rd);
    checkOutput("w1c_vs_set", rd, 32'h1);
    apbWrite(16'h04, 32'h10);
    apbRead(16'h04, rd);
    checkOutput("value_write_vs_tick", rd, 32'h10);
    stopTimer();

    $display("[TB] reload zero");
    apbWrite(16'h04, 32'h0);
    apbWrite(16'h08, 32'h0);
    apbWrite(16'h00, 32'h3);
    t0 = cyc;
    waitIrq(t0, delta);
    checkOutput("every_cycle_delay", delta, 32'd1);
    apbWrite(16'h10, 32'h1);
    apbRead(16'h10, rd);
    checkOutput("every_cycle_pending", rd, 32'h1);
    apbRead(16'h04, rd);
    checkOutput("every_cycle_value", rd, 32'h0);

    $display("[TB] reset mid-count");
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    checkOutput("midreset_irq", {31'h0, TIMER_IRQ}, 32'h0);
    apbRead(16'h00, rd);
    checkOutput("midreset_ctrl", rd, 32'h0);
    apbRead(16'h10, rd);
    checkOutput("midreset_pending", rd, 32'h0);

    $display("[TB] randomized periods");
    for (int k = 0; k < 10; k++) begin
      p  = $urandom_range(0, 3);
      r  = $urandom_range(3, 6);
      v  = $urandom_range(0, 6);
      os = 1'($urandom_range(0, 1));
      stopTimer();
      apbWrite(16'h0C, 32'(p));
      apbWrite(16'h08, 32'(r));
      apbWrite(16'h04, 32'(v));
      apbWrite(16'h00, {29'h0, os, 2'b11});
      t0 = cyc;
      waitIrq(t0, delta);
      checkOutput($sformatf("rand%0d_first", k), delta, 32'((v + 1) * (p + 1)));
      t1 = cyc;
      if (os) begin
        apbRead(16'h00, rd);
        checkOutput($sformatf("rand%0d_ctrl", k), rd, 32'h6);
        apbRead(16'h04, rd);
        checkOutput($sformatf("rand%0d_value", k), rd, 32'(r));
      end else begin
        apbWrite(16'h10, 32'h1);
        checkOutput($sformatf("rand%0d_w1c", k), {31'h0, TIMER_IRQ}, 32'h0);
        waitIrq(t1, delta);
        checkOutput($sformatf("rand%0d_period", k), delta, 32'((r + 1) * (p + 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
32-bit down-counting timer peripheral on the APB side of the AHB-to-APB bridge. It consumes the bridge's APB master outputs and returns PRDATA/PREADY/PSLVERR. It provides a programmable prescaler, auto-reload and one-shot modes, and a level interrupt. Zero wait-state slave in the PCLK domain.

Parameters:
ADDR_WIDTH, 16, width of PADDR (matches bridge); only PADDR[4:0] decoded
DATA_WIDTH, 32, APB data width; PSTRB width = DATA_WIDTH/8
PRE_W, 8, prescaler register width

Ports:
PCLK  in  1  APB clock, single clock for whole block
PRESETn  in  1  synchronous active-low reset
PSEL  in  1  slave select from bridge
PENABLE  in  1  access-phase indicator
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  write byte strobes
PPROT  in  3  ignored
PRDATA  out  DATA_WIDTH  read data, valid in access phase
PREADY  out  1  tied 1
PSLVERR  out  1  error for unmapped address
TIMER_IRQ  out  1  interrupt, level high

Behaviour:
- Clock/reset: one clock PCLK; reset is synchronous, active-low (PRESETn), sampled on PCLK rising edge.
- Reset: CTRL, VALUE, RELOAD, PRESCALE, pending, prescaler counter, PRDATA = 0; PSLVERR=0; TIMER_IRQ=0; PREADY=1 always.
- Register map (PADDR[4:0]): 0x00 CTRL {bit2 ONESHOT, bit1 IRQ_EN, bit0 EN}; 0x04 VALUE (RW); 0x08 RELOAD (RW); 0x0C PRESCALE (PRE_W bits, upper bits read 0); 0x10 INTSTATUS bit0 pending (read; write 1 clears). Unlisted bits read 0.
- Setup phase (PSEL=1, PENABLE=0, PWRITE=0): PRDATA registered from addressed register, valid through access phase. Otherwise PRDATA holds.
- Access phase write (PSEL & PENABLE & PWRITE): register updates on that edge. Byte-lane i written only if PSTRB[i]. CTRL/INTSTATUS use PSTRB[0] only.
- PSLVERR: combinational, 1 in access phase when PADDR[4:0] > 0x10 or PADDR[1:0] != 0; write ignored, PRDATA = 0.
- Prescaler: when EN=1, pcnt increments each cycle; tick when pcnt == PRESCALE, then pcnt returns to 0. EN=0: pcnt held at 0, no ticks.
- On tick: VALUE!=0 -> VALUE-1. VALUE==0 -> VALUE<=RELOAD, pending<=1, and if ONESHOT then EN<=0.
- Period from VALUE=RELOAD: (RELOAD+1)*(PRESCALE+1) cycles between pending sets.
- TIMER_IRQ = pending & IRQ_EN (combinational from flops).
- Simultaneous: APB write to VALUE on a tick edge -> written value wins, pcnt reset to 0. Write to PRESCALE resets pcnt to 0. W1C of pending on same edge as a set -> set wins. CTRL write EN=1 plus tick same edge impossible (EN was 0).
- VALUE arithmetic is modulo 2^32; RELOAD=0 with PRESCALE=0 gives pending set every cycle.
- Reset mid-count: all state to reset values on the next PCLK edge with PRESETn=0, regardless of APB phase.

Test Plan:
- Reset: hold PRESETn=0 5 cycles, read all 5 registers -> all 0, PSLVERR=0, TIMER_IRQ=0.
- Periodic: RELOAD=3, VALUE=3, PRESCALE=1, CTRL=0x3 -> TIMER_IRQ rises 8 cycles after CTRL write; W1C 0x10 clears it; next rise 8 cycles later; VALUE reads 3 after reload.
- One-shot: RELOAD=5, VALUE=2, PRESCALE=0, CTRL=0x7 -> pending after 3 cycles, CTRL reads 0x6, VALUE stays 5.
- Collisions: W1C issued on the edge pending sets -> pending stays 1; write VALUE=0x10 on a tick edge -> reads 0x10.
- Byte strobes: RELOAD=0xFFFFFFFF, then write 0x12345678 with PSTRB=4'b0101 -> reads 0xFF34FF78.
- Errors: read 0x14 and write 0x06 -> PSLVERR=1, PRDATA=0, no register changes; PREADY=1 throughout.
